// File: rtl/limit_counter.sv
// limit_counter: parametrised up/down counter with a double-buffered limit,
// wrap or saturate behaviour at the bounds, synchronous clear/load and
// status flags (terminal count, wrap pulse, saturation, sticky overflow).
//
// Optional feature: define LIMIT_COUNTER_PRESCALE_EN to divide step requests
// by PRESCALE. A step then happens only on every PRESCALE-th enabled cycle.
// Without the macro, every enabled cycle is a step and PRESCALE is ignored.
//
// The active bound (limit_q) is only refreshed from limit_i on clear, load
// or a wrap. This lets a period change take effect at a period boundary
// and never in the middle of a count.

module limit_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             up_down_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_pulse_o,
  output logic             sat_o,
  output logic             ovf_sticky_o
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             step_s;

`ifdef LIMIT_COUNTER_PRESCALE_EN
  // The prescaler needs at least one bit, even when PRESCALE is 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          pre_hit_s;

  // Prescaler next state: advance on enabled cycles and restart on clear/load.
  always_comb begin
    pre_d     = pre_q;
    pre_hit_s = 1'b0;
    if (clear_i || load_i) begin
      pre_d = '0;
    end else if (enable_i) begin
      if (pre_q == PRE_LAST) begin
        pre_d     = '0;
        pre_hit_s = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else begin
      pre_d = pre_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign step_s = enable_i & pre_hit_s;
`else
  assign step_s = enable_i;
`endif

  // Counter next state: clear beats load, and load beats a step.
  always_comb begin
    count_d = count_q;
    limit_d = limit_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      count_d = '0;
      limit_d = limit_i;
      sat_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      // Clamp against the limit being captured now, not the old one.
      limit_d = limit_i;
      count_d = (load_value_i > limit_i) ? limit_i : load_value_i;
      sat_d   = 1'b0;
    end else if (step_s) begin
      if (up_down_i) begin
        if (count_q < limit_q) begin
          count_d = count_q + ONE;
          sat_d   = 1'b0;
        end else if (!mode_i) begin
          // A wrap is a safe point to pick up a new period.
          count_d = '0;
          limit_d = limit_i;
          wrap_d  = 1'b1;
          sat_d   = 1'b0;
          ovf_d   = 1'b1;
        end else begin
          sat_d = 1'b1;
          ovf_d = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - ONE;
          sat_d   = 1'b0;
        end else if (!mode_i) begin
          // A downward wrap reloads to the newly captured limit.
          count_d = limit_i;
          limit_d = limit_i;
          wrap_d  = 1'b1;
          sat_d   = 1'b0;
          ovf_d   = 1'b1;
        end else begin
          sat_d = 1'b1;
          ovf_d = 1'b1;
        end
      end
    end else begin
      // No step: hold the state. wrap_d is already 0, so the pulse ends.
      count_d = count_q;
      limit_d = limit_q;
    end
  end

  // Counter, active limit and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      limit_q <= ALL_ONES;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o      = count_q;
  assign tc_o         = up_down_i ? (count_q == limit_q) : (count_q == '0);
  assign wrap_pulse_o = wrap_q;
  assign sat_o        = sat_q;
  assign ovf_sticky_o = ovf_q;

endmodule
